// File: rtl/fetch_ctrl.sv
// LC-3b instruction fetch sequencer: owns the PC, runs the I-cache read handshake,
// and holds the fetched instruction until decode accepts it.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        icache_read,
  output logic [15:0] icache_address,
  input  logic        icache_resp,
  input  logic [15:0] icache_rdata,
  output logic        ir_load,
  output logic [15:0] ir_data,
  output logic        inst_valid,
  output logic [15:0] inst_pc,
  input  logic        decode_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] pend_pc, pend_pc_next;
  logic        inst_valid_next;
  logic [15:0] inst_pc_next;
  logic [15:0] redirect_target;

  assign redirect_target = redirect_pc & 16'hFFFE;
  assign icache_address  = pc;
  assign ir_data         = icache_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC & 16'hFFFE;
      pend_pc    <= 16'h0000;
      inst_valid <= 1'b0;
      inst_pc    <= 16'h0000;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pend_pc    <= pend_pc_next;
      inst_valid <= inst_valid_next;
      inst_pc    <= inst_pc_next;
    end
  end

  // FLUSH keeps pc at the outstanding address so the cache sees a stable request
  // while the redirect target waits in pend_pc.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pend_pc_next    = pend_pc;
    inst_valid_next = inst_valid;
    inst_pc_next    = inst_pc;
    icache_read     = 1'b0;
    ir_load         = 1'b0;

    unique case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect) pc_next = redirect_target;
      end

      FETCH: begin
        icache_read = 1'b1;
        if (icache_resp && !redirect) begin
          ir_load         = 1'b1;
          inst_pc_next    = pc;
          pc_next         = pc + 16'd2;
          inst_valid_next = 1'b1;
          state_next      = HOLD;
        end else if (icache_resp && redirect) begin
          pc_next = redirect_target;
        end else if (redirect) begin
          pend_pc_next = redirect_target;
          state_next   = FLUSH;
        end
      end

      HOLD: begin
        if (redirect) begin
          inst_valid_next = 1'b0;
          pc_next         = redirect_target;
          state_next      = FETCH;
        end else if (decode_ready) begin
          inst_valid_next = 1'b0;
          state_next      = FETCH;
        end
      end

      FLUSH: begin
        icache_read = 1'b1;
        if (redirect) pend_pc_next = redirect_target;
        if (icache_resp) begin
          pc_next    = redirect ? redirect_target : pend_pc;
          state_next = FETCH;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the LC-3b core: owns the PC, drives the I-cache read handshake, and generates the load strobe and data for the instruction register.
- Holds each fetched instruction valid until decode accepts it.
- Handles control-flow redirects, including a redirect that arrives while an I-cache read is still outstanding.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- icache_read  out  1  I-cache read request
- icache_address  out  16  I-cache read address (lc3b_word)
- icache_resp  in  1  I-cache response, one-cycle pulse, data valid same cycle
- icache_rdata  in  16  I-cache read data
- ir_load  out  1  IR load strobe
- ir_data  out  16  word to IR input; equals icache_rdata
- inst_valid  out  1  IR holds an instruction not yet accepted by decode
- inst_pc  out  16  address of the instruction currently in the IR
- decode_ready  in  1  decode accepts the current instruction this cycle
- redirect  in  1  control-flow redirect (branch/JMP/TRAP/JSR)
- redirect_pc  in  16  redirect target; bit 0 ignored (forced to 0)

Behaviour:
- State registers: state, pc, pend_pc, inst_valid, inst_pc. State encodings are IDLE, FETCH, HOLD, FLUSH.
- Reset (synchronous, priority over everything):
  - state<=IDLE, pc<=RESET_PC, pend_pc<=0, inst_valid<=0, inst_pc<=0.
  - An in-flight I-cache read is abandoned; the I-cache is reset on the same signal.
- Outputs are combinational from state and inputs:
  - icache_read=1 in FETCH and FLUSH, else 0.
  - icache_address=pc in FETCH; pc in FLUSH (the outstanding address); pc otherwise.
  - ir_load=1 only when state=FETCH, icache_resp=1 and redirect=0.
  - ir_data=icache_rdata always.
- IDLE:
  - Outputs read=0, ir_load=0.
  - Next state FETCH unconditionally; if redirect=1, pc<=redirect_pc.
- FETCH:
  - icache_read and icache_address stay stable until icache_resp.
  - resp=1, redirect=0: ir_load=1, inst_pc<=pc, pc<=pc+2, inst_valid<=1, next state HOLD.
  - resp=1, redirect=1: data discarded, pc<=redirect_pc, stay in FETCH. The new address appears the next cycle; icache_read stays high (back-to-back request).
  - resp=0, redirect=1: the read must complete, so pend_pc<=redirect_pc and next state FLUSH.
  - resp=0, redirect=0: stay.
- HOLD:
  - inst_valid=1 and the IR is not reloaded.
  - redirect=1 (priority over decode_ready): inst_valid<=0, pc<=redirect_pc, next state FETCH.
  - decode_ready=1, redirect=0: inst_valid<=0, next state FETCH (fetches pc, already advanced).
  - Otherwise stay; the instruction is held indefinitely.
- FLUSH:
  - Keeps the read asserted at the original address; ir_load=0.
  - redirect=1 in FLUSH: pend_pc<=redirect_pc (latest redirect wins).
  - On resp: data discarded, pc<=pend_pc (or redirect_pc if redirect is high this cycle), next state FETCH.
- Arithmetic: pc+2 is 16-bit modulo, so 16'hFFFE wraps to 16'h0000. redirect_pc bit 0 is zeroed on capture.
- Latency:
  - Resp-to-inst_valid is 1 cycle.
  - decode_ready to the next icache_read is 1 cycle.
  - Minimum 2 cycles per instruction with a 1-cycle cache.
- Invariants:
  - ir_load never asserts while inst_valid=1 and decode_ready=0.
  - At most one outstanding I-cache read.
  - ir_load never asserts for a read issued before the most recent redirect.

Test Plan:
- Reset with RESET_PC=16'h0000; cache responds 1 cycle after each read with rdata=16'h1234 → IDLE one cycle. First read addr 0; ir_load with ir_data=16'h1234; inst_valid=1 and inst_pc=0 next cycle; next read addr 2.
- decode_ready held 0 for 5 cycles in HOLD → inst_valid stays 1, icache_read=0, ir_load=0. On decode_ready=1, the next cycle reads addr pc+2.
- Redirect to 16'h3001 in HOLD together with decode_ready=1 → inst_valid=0 next cycle; next read addr 16'h3000.
- Redirect to 16'h4000 while a read of 16'h0010 waits 3 cycles for resp → FLUSH. Address stays 16'h0010 until resp; no ir_load; the following read is at 16'h4000. A second redirect to 16'h5000 during FLUSH gives a following read at 16'h5000.
- Redirect coincident with resp in FETCH → no ir_load; the next cycle reads redirect_pc. PC at 16'hFFFE fetched and accepted → the next read address is 16'h0000.
- Reset asserted mid-FETCH and mid-HOLD → the next cycle is IDLE with inst_valid=0, read=0 and pc=RESET_PC.
